sobel_edge_detector: RTL and testbench
======================================

Name: sobel_edge_detector

Overview:
- Consumes the blurred grayscale frame that the Gaussian stage leaves in frame memory (36-bit YCrCb words, Y in bits [29:20]).
- Applies 3x3 Sobel operators and writes an edge-magnitude frame back as grayscale YCrCb, ready for the thresholding/line-finding stage.
- Streams one 3x3 window column per slot and uses the same start/done memory-master interface as the blur stage.

Parameters:
- WIDTH, 640, image width in pixels (column index 10 bits).
- HEIGHT, 480, image height in lines (row index 9 bits).
- THRESHOLD, 300, binarisation level on raw magnitude; used only with SOBEL_THRESHOLD_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins, or restarts, a frame.
- done  out  1  one-cycle pulse after the last pixel write.
- read_addr  out  19  frame memory read address {row[8:0], col[9:0]}.
- read_data  in  36  memory word; valid 2 cycles after read_addr is presented.
- write_addr  out  19  output address {y[8:0], x[9:0]}.
- write_data  out  36  {6'b0, edge_Y[9:0], 10'd512, 10'd512}.
- write_en  out  1  one-cycle strobe qualifying write_addr/write_data.

Behaviour:
- Reset (async): all outputs 0; FSM IDLE; window registers 0. Reset dominates start.
- States: IDLE -> RUN on start; RUN -> IDLE after the final slot. A start in RUN restarts at row 0, column 0, clears the window, and suppresses done.
- Frame order: rows y=0..HEIGHT-1; per row, column slots cx=0..WIDTH (WIDTH+1 slots). Each slot is 8 cycles, so a frame takes HEIGHT*(WIDTH+1)*8 cycles from start to done.
- Slot cycle 0: read_addr={y-1,cx}.
- Slot cycle 1: read_addr={y,cx}.
- Slot cycle 2: read_addr={y+1,cx}.
- Slot cycles 2/3/4: capture read_data[29:20] as new top/mid/bottom samples.
- Zero substitution: a sample is forced to 0 if its row is <0 or >=HEIGHT, or if cx==WIDTH. The address is still driven, wrapped mod field width, and the data is ignored.
- Slot cycle 5: shift the window left one column and load the new samples into column 2. At row start (cx=0), columns 0 and 1 are cleared first.
- Slot cycle 6: compute gradients (window centred at x=cx-1):
  - Gx = (t2+2m2+b2)-(t0+2m0+b0); Gy = (b0+2b1+b2)-(t0+2t1+t2). Both are 13-bit signed, range ±4092.
  - mag = |Gx|+|Gy|, 13-bit unsigned, max 8184.
  - edge_Y = min(mag>>2, 1023).
- Slot cycle 7: if cx>=1, write_en=1, write_addr={y,cx-1}, write_data per the port format.
- Border pixels (x==0, x==WIDTH-1, y==0, y==HEIGHT-1) are written with edge_Y=0.
- Slot cx=0 produces no write. Exactly WIDTH*HEIGHT writes per frame.
- done: asserted the cycle after RUN->IDLE, for exactly 1 cycle. write_en is never asserted in IDLE.
- write_addr/write_data hold their last values between strobes.

Optional Feature:
- SOBEL_THRESHOLD_EN defined: edge_Y = (mag >= THRESHOLD) ? 1023 : 0. Border pixels are still 0.
- Undefined: scaled, saturated magnitude as above; the THRESHOLD parameter is unused.

Decomposition:
- Shared package image_pkg:
  - ADDR_W=19, DATA_W=36, Y_MSB=29, Y_LSB=20, CHROMA_NEUTRAL=10'd512.
  - Function pack_addr(row,col).
  - Same package used by gaussian_blurrer and downstream stages.
- Sub-module sobel_magnitude: combinational, inputs 9 10-bit samples, outputs the 13-bit mag and 10-bit edge_Y. Unit-testable separately.

Test Plan (WIDTH=8, HEIGHT=6 behavioural memory, 2-cycle read latency):
- Uniform frame, Y=700 -> 48 writes, all write_data={6'b0,10'd0,10'd512,10'd512}. done 432 cycles after start, 1 cycle wide.
- Vertical step: Y=0 for x<4, 1023 for x>=4 -> interior rows, x=3 and x=4: mag 4092, edge_Y=1023. All other interior pixels 0.
- Single pixel Y=400 at (3,2), rest 0 -> (2,2) and (4,2): mag 800, edge_Y=200. Diagonal neighbours (2,1): mag 800, edge_Y=200. (3,1): mag 800, edge_Y=200. Centre edge_Y=0.
- Border check: random frame -> every write with x∈{0,7} or y∈{0,5} carries edge_Y=0. Write addresses are a strictly increasing row-major sequence, no duplicates.
- Reset asserted mid-frame (cycle 150) -> outputs 0 same cycle, no done. A new start gives a full correct frame of 48 writes.
- SOBEL_THRESHOLD_EN, THRESHOLD=300, single-pixel test above -> pixels with mag 800 give edge_Y=1023; all others 0.

Source files
------------

// File: rtl/image_pkg.sv
// image_pkg: frame-memory word/address layout shared by the blur, Sobel and downstream stages.
package image_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;
  localparam int Y_MSB = 29;
  localparam int Y_LSB = 20;
  localparam int ROW_W = 9;
  localparam int COL_W = 10;
  localparam int PIX_W = 10;
  localparam int MAG_W = 13;
  localparam logic [PIX_W-1:0] CHROMA_NEUTRAL = 10'd512;
  typedef enum logic {IDLE, RUN} run_state_e;
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return {row, col};
  endfunction
  function automatic logic [DATA_W-1:0] pack_gray(input logic [PIX_W-1:0] y);
    return {6'b0, y, CHROMA_NEUTRAL, CHROMA_NEUTRAL};
  endfunction
endpackage

// File: rtl/sobel_magnitude.sv
// sobel_magnitude: combinational 3x3 Sobel |Gx|+|Gy| and its 10-bit luma mapping.
// SOBEL_THRESHOLD_EN selects a binary edge map at THRESHOLD instead of the scaled magnitude.
module sobel_magnitude
  import image_pkg::*;
#(
  parameter int THRESHOLD = 300
) (
  input  logic [PIX_W-1:0] t0,
  input  logic [PIX_W-1:0] t1,
  input  logic [PIX_W-1:0] t2,
  input  logic [PIX_W-1:0] m0,
  input  logic [PIX_W-1:0] m1,
  input  logic [PIX_W-1:0] m2,
  input  logic [PIX_W-1:0] b0,
  input  logic [PIX_W-1:0] b1,
  input  logic [PIX_W-1:0] b2,
  output logic [MAG_W-1:0] mag,
  output logic [PIX_W-1:0] edge_y
);
  logic [11:0] right, left, bottom, top;
  logic signed [MAG_W-1:0] gx, gy;
  logic [MAG_W-1:0] ax, ay;
  always_comb begin
    right  = 12'(t2) + 12'({m2, 1'b0}) + 12'(b2);
    left   = 12'(t0) + 12'({m0, 1'b0}) + 12'(b0);
    bottom = 12'(b0) + 12'({b1, 1'b0}) + 12'(b2);
    top    = 12'(t0) + 12'({t1, 1'b0}) + 12'(t2);
    gx = $signed({1'b0, right}) - $signed({1'b0, left});
    gy = $signed({1'b0, bottom}) - $signed({1'b0, top});
    ax = gx[MAG_W-1] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[MAG_W-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = ax + ay;
`ifdef SOBEL_THRESHOLD_EN
    edge_y = (mag >= MAG_W'(THRESHOLD)) ? 10'd1023 : 10'd0;
`else
    edge_y = mag[MAG_W-1] ? 10'd1023 : mag[11:2];
`endif
  end
`ifndef SOBEL_THRESHOLD_EN
  logic unused_threshold;
  assign unused_threshold = (THRESHOLD != 0);
`endif
endmodule

// File: rtl/sobel_edge_detector.sv
// sobel_edge_detector: streams a blurred frame through a 3x3 Sobel window, writes edge luma back.
// Optional binarisation with SOBEL_THRESHOLD_EN.
module sobel_edge_detector
  import image_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int THRESHOLD = 300
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en
);
  localparam logic [COL_W-1:0] LAST_CX = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] LAST_Y = ROW_W'(HEIGHT - 1);
  run_state_e state, next_state;
  logic [2:0] phase;
  logic [COL_W-1:0] cx;
  logic [ROW_W-1:0] y, read_row;
  logic [2:0][PIX_W-1:0] win_t, win_m, win_b;
  logic [PIX_W-1:0] new_t, new_m, new_b, sample, edge_y;
  logic [MAG_W-1:0] unused_mag;
  logic last_slot, pad_col, border, unused_rd;
  assign sample = read_data[Y_MSB:Y_LSB];
  assign unused_rd = ^{read_data[DATA_W-1:Y_MSB+1], read_data[Y_LSB-1:0]};
  assign pad_col = (cx == LAST_CX);
  assign last_slot = (phase == 3'd7) && pad_col && (y == LAST_Y);
  // The written pixel sits at x = cx-1, so the x borders are cx==1 and cx==WIDTH.
  assign border = (cx == 10'd1) || pad_col || (y == '0) || (y == LAST_Y);
  sobel_magnitude #(.THRESHOLD(THRESHOLD)) u_mag (
    .t0(win_t[0]), .t1(win_t[1]), .t2(win_t[2]),
    .m0(win_m[0]), .m1(win_m[1]), .m2(win_m[2]),
    .b0(win_b[0]), .b1(win_b[1]), .b2(win_b[2]),
    .mag(unused_mag),
    .edge_y(edge_y)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    if (start) next_state = RUN;
    else if (state == RUN && last_slot) next_state = IDLE;
  end
  always_comb begin
    read_row = (phase == 3'd0) ? y - 9'd1 : (phase == 3'd1) ? y : y + 9'd1;
    read_addr = (state == RUN && phase <= 3'd2) ? pack_addr(read_row, cx) : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      cx <= '0;
      y <= '0;
      win_t <= '0;
      win_m <= '0;
      win_b <= '0;
      new_t <= '0;
      new_m <= '0;
      new_b <= '0;
      done <= 1'b0;
      write_en <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      done <= (state == RUN) && (next_state == IDLE);
      write_en <= 1'b0;
      if (start) begin
        phase <= '0;
        cx <= '0;
        y <= '0;
        win_t <= '0;
        win_m <= '0;
        win_b <= '0;
      end else if (state == RUN) begin
        phase <= phase + 3'd1;
        if (phase == 3'd7) begin
          cx <= pad_col ? '0 : cx + 10'd1;
          if (pad_col) y <= y + 9'd1;
        end
        // Out-of-frame rows and the padding column read as black.
        if (phase == 3'd2) new_t <= (y == '0 || pad_col) ? '0 : sample;
        if (phase == 3'd3) new_m <= pad_col ? '0 : sample;
        if (phase == 3'd4) new_b <= (y == LAST_Y || pad_col) ? '0 : sample;
        if (phase == 3'd5) begin
          win_t <= {new_t, win_t[2], (cx == '0) ? PIX_W'(0) : win_t[1]};
          win_m <= {new_m, win_m[2], (cx == '0) ? PIX_W'(0) : win_m[1]};
          win_b <= {new_b, win_b[2], (cx == '0) ? PIX_W'(0) : win_b[1]};
        end
        if (phase == 3'd6 && cx != '0) begin
          write_en <= 1'b1;
          write_addr <= pack_addr(y, cx - 10'd1);
          write_data <= pack_gray(border ? PIX_W'(0) : edge_y);
        end
      end
    end
  end
endmodule

// File: tb/tb_sobel_edge_detector.sv
// tb_sobel_edge_detector: scoreboard bench on an 8x6 frame with a 2-cycle-latency memory model.
module tb_sobel_edge_detector;
  localparam int W = 8;
  localparam int H = 6;
  logic clk = 0, reset = 0, start = 0;
  logic done, write_en;
  logic [18:0] read_addr, write_addr, a1;
  logic [35:0] read_data, write_data;
  int img[H][W];
  int got_edge[H][W];
  int vectors = 0, errors = 0;
  logic [54:0] sb[$];

  always #5 clk = ~clk;

  sobel_edge_detector #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(300)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .read_addr(read_addr), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en)
  );

  // Out-of-frame reads return all-ones so any missed zero substitution shows up.
  function automatic logic [35:0] mem_word(input logic [18:0] a);
    int r, c;
    r = int'(a[18:10]);
    c = int'(a[9:0]);
    if (r < H && c < W) return {6'h2A, 10'(img[r][c]), 20'h5A5A5};
    return '1;
  endfunction

  always @(posedge clk) begin
    a1 <= read_addr;
    read_data <= mem_word(a1);
  end

  function automatic int px(input int x, input int y);
    return (x < 0 || x >= W || y < 0 || y >= H) ? 0 : img[y][x];
  endfunction

  function automatic logic [9:0] exp_edge(input int x, input int y);
    int gx, gy, mag;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 10'd0;
    gx = px(x+1, y-1) + 2*px(x+1, y) + px(x+1, y+1) - px(x-1, y-1) - 2*px(x-1, y) - px(x-1, y+1);
    gy = px(x-1, y+1) + 2*px(x, y+1) + px(x+1, y+1) - px(x-1, y-1) - 2*px(x, y-1) - px(x+1, y-1);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= 300) ? 10'd1023 : 10'd0;
`else
    return (mag / 4 > 1023) ? 10'd1023 : 10'(mag / 4);
`endif
  endfunction

  task automatic run_frame(input string name);
    logic [54:0] exp;
    logic [18:0] last;
    int n;
    bit got_done, first;
    sb.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        sb.push_back({9'(y), 10'(x), 6'b0, exp_edge(x, y), 10'd512, 10'd512});
        got_edge[y][x] = -1;
      end
    start = 1;
    @(posedge clk);
    #1 start = 0;
    n = 0;
    got_done = 0;
    first = 1;
    last = '0;
    while (!got_done && n < 2000) begin
      @(posedge clk);
      #1 n++;
      if (write_en === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_write addr=%h", name, write_addr);
        end else begin
          exp = sb.pop_front();
          if ({write_addr, write_data} !== exp) begin
            errors++;
            $display("FAIL %s write got=%h/%h want=%h/%h", name, write_addr, write_data, exp[54:36], exp[35:0]);
          end
        end
        if (!first) begin
          vectors++;
          if (write_addr <= last) begin
            errors++;
            $display("FAIL %s addr_order got=%h after=%h", name, write_addr, last);
          end
        end
        if (int'(write_addr[18:10]) < H && int'(write_addr[9:0]) < W)
          got_edge[write_addr[18:10]][write_addr[9:0]] = int'(write_data[29:20]);
        first = 0;
        last = write_addr;
      end
      got_done = (done === 1'b1);
    end
    vectors++;
    if (!got_done || n != 432) begin
      errors++;
      $display("FAIL %s done_latency got=%0d(done=%0b) want=432", name, n, got_done);
    end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_writes got=%0d want=0", name, sb.size());
    end
    @(posedge clk);
    #1 vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width got=%b want=0", name, done);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++;
    if ({done, write_en, read_addr, write_addr, write_data} !== '0) begin
      errors++;
      $display("FAIL %s outputs got=%b/%b/%h/%h/%h want=0", name, done, write_en, read_addr, write_addr, write_data);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset");
    reset = 0;
  endtask

  task automatic test_uniform();
    foreach (img[y, x]) img[y][x] = 700;
    run_frame("uniform");
    vectors++;
    if (got_edge[2][3] !== 0) begin
      errors++;
      $display("FAIL uniform_centre got=%0d want=0", got_edge[2][3]);
    end
  endtask

  task automatic test_vertical_step();
    foreach (img[y, x]) img[y][x] = (x < 4) ? 0 : 1023;
    run_frame("vstep");
    for (int y = 1; y < H - 1; y++) begin
      vectors++;
      if (got_edge[y][3] !== 1023 || got_edge[y][4] !== 1023 || got_edge[y][2] !== 0 || got_edge[y][5] !== 0) begin
        errors++;
        $display("FAIL vstep_row%0d got=%0d,%0d,%0d,%0d want=0,1023,1023,0", y, got_edge[y][2], got_edge[y][3], got_edge[y][4], got_edge[y][5]);
      end
    end
  endtask

  task automatic test_single_pixel();
    int hi;
`ifdef SOBEL_THRESHOLD_EN
    hi = 1023;
`else
    hi = 200;
`endif
    foreach (img[y, x]) img[y][x] = 0;
    img[2][3] = 400;
    run_frame("pixel");
    vectors++;
    if (got_edge[2][2] !== hi || got_edge[2][4] !== hi || got_edge[1][2] !== hi || got_edge[1][3] !== hi || got_edge[2][3] !== 0) begin
      errors++;
      $display("FAIL pixel_points got=%0d,%0d,%0d,%0d,%0d want=%0d,%0d,%0d,%0d,0", got_edge[2][2], got_edge[2][4], got_edge[1][2], got_edge[1][3], got_edge[2][3], hi, hi, hi, hi);
    end
  endtask

  task automatic test_random_border();
    foreach (img[y, x]) img[y][x] = int'($urandom_range(0, 1023));
    run_frame("random");
    foreach (got_edge[y, x])
      if (x == 0 || x == W - 1 || y == 0 || y == H - 1) begin
        vectors++;
        if (got_edge[y][x] !== 0) begin
          errors++;
          $display("FAIL border x=%0d y=%0d got=%0d want=0", x, y, got_edge[y][x]);
        end
      end
  endtask

  task automatic test_reset_mid();
    bit saw_done = 0;
    foreach (img[y, x]) img[y][x] = (x * 37 + y * 91) % 1024;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (150) begin
      @(posedge clk);
      #1 if (done === 1'b1) saw_done = 1;
    end
    #2 reset = 1;
    #1 check_outputs_zero("reset_mid");
    repeat (2) begin
      @(posedge clk);
      #1 if (done !== 1'b0) saw_done = 1;
    end
    reset = 0;
    vectors++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_mid_done got=1 want=0");
    end
    run_frame("after_reset");
  endtask

  task automatic test_back_to_back();
    bit saw_done = 0;
    foreach (img[y, x]) img[y][x] = (x * 211 + y * 53) % 1024;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (100) begin
      @(posedge clk);
      #1 if (done === 1'b1) saw_done = 1;
    end
    vectors++;
    if (saw_done) begin
      errors++;
      $display("FAIL restart_done got=1 want=0");
    end
    run_frame("restart");
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_vertical_step();
    test_single_pixel();
    test_random_border();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
